// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI-style burst slave RAM with independent write and read FSMs
// Optional build macro: AXI_SLAVE_RAM_ID_FILTER_EN (accept only requests whose ID equals parameter ID)
module axi_slave_ram #(
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 64,
   parameter int IDSIZE = 4,
   parameter int LSIZE  = 8,
   parameter int ID     = 0,
   parameter int DEPTH  = 1024
) (
   input  logic              axi_aclk,
   input  logic              axi_resetn,
   input  logic [IDSIZE-1:0] axi_awid,
   input  logic [ASIZE-1:0]  axi_awaddr,
   input  logic [LSIZE-1:0]  axi_awlen,
   input  logic              axi_awvalid,
   output logic              axi_awready,
   input  logic [DSIZE-1:0]  axi_wdata,
   input  logic              axi_wlast,
   input  logic              axi_wvalid,
   output logic              axi_wready,
   output logic [IDSIZE-1:0] axi_bid,
   output logic [1:0]        axi_bresp,
   output logic              axi_bvalid,
   input  logic              axi_bready,
   input  logic [IDSIZE-1:0] axi_arid,
   input  logic [ASIZE-1:0]  axi_araddr,
   input  logic [LSIZE-1:0]  axi_arlen,
   input  logic              axi_arvalid,
   output logic              axi_arready,
   output logic [IDSIZE-1:0] axi_rid,
   output logic [DSIZE-1:0]  axi_rdata,
   output logic [1:0]        axi_rresp,
   output logic              axi_rlast,
   output logic              axi_rvalid,
   input  logic              axi_rready
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = LSIZE + 1;   // holds len+1 without overflow
   localparam int CW = LSIZE + 2;   // write beat counter, saturating, wider than any legal length

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   logic [DSIZE-1:0] mem_q [DEPTH];

   w_state_t          w_state_q, w_state_d;
   logic [IDSIZE-1:0] bid_q, bid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [AW-1:0]     widx_q, widx_d;
   logic [LW-1:0]     wlen_q, wlen_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [CW-1:0]     wcnt_inc;
   logic              mem_we;

   r_state_t          r_state_q, r_state_d;
   logic [IDSIZE-1:0] rid_q, rid_d;
   logic [DSIZE-1:0]  rdata_q, rdata_d;
   logic              rlast_q, rlast_d;
   logic [AW-1:0]     ridx_q, ridx_d;
   logic [AW-1:0]     ridx_nxt;
   logic [LW-1:0]     rlen_q, rlen_d;
   logic [LW-1:0]     rcnt_q, rcnt_d;

   logic              aw_id_ok;
   logic              ar_id_ok;

`ifdef AXI_SLAVE_RAM_ID_FILTER_EN
   assign aw_id_ok = axi_awvalid && (axi_awid == IDSIZE'(ID));
   assign ar_id_ok = axi_arvalid && (axi_arid == IDSIZE'(ID));
`else
   logic [IDSIZE-1:0] unused_id;
   assign unused_id = IDSIZE'(ID);
   assign aw_id_ok  = 1'b1;
   assign ar_id_ok  = 1'b1;
`endif

   // Only the low index bits address the array; the rest of the address bus is ignored.
   logic unused_addr;
   assign unused_addr = ^{axi_awaddr[ASIZE-1:AW], axi_araddr[ASIZE-1:AW]};

   assign wcnt_inc  = (&wcnt_q) ? wcnt_q : wcnt_q + CW'(1);
   assign ridx_nxt  = ridx_q + AW'(1);
   assign axi_bid   = bid_q;
   assign axi_bresp = bresp_q;
   assign axi_rid   = rid_q;
   assign axi_rdata = rdata_q;
   assign axi_rlast = rlast_q;
   assign axi_rresp = 2'b00;

   // Write channel: address accept, data beats into memory, then hold the response
   always_comb begin
      w_state_d   = w_state_q;
      bid_d       = bid_q;
      bresp_d     = bresp_q;
      widx_d      = widx_q;
      wlen_d      = wlen_q;
      wcnt_d      = wcnt_q;
      mem_we      = 1'b0;
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      axi_bvalid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            axi_awready = axi_resetn && aw_id_ok;
            if (axi_awvalid && axi_awready) begin
               bid_d     = axi_awid;
               widx_d    = axi_awaddr[AW-1:0];
               wlen_d    = LW'(axi_awlen) + LW'(1);
               wcnt_d    = '0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            axi_wready = 1'b1;
            if (axi_wvalid) begin
               mem_we = 1'b1;
               widx_d = widx_q + AW'(1);
               wcnt_d = wcnt_inc;
               if (axi_wlast) begin
                  bresp_d   = (wcnt_inc != CW'(wlen_q)) ? 2'b10 : 2'b00;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            axi_bvalid = 1'b1;
            if (axi_bready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: registered read so a same-cycle write is seen only on later beats
   always_comb begin
      r_state_d   = r_state_q;
      rid_d       = rid_q;
      rdata_d     = rdata_q;
      rlast_d     = rlast_q;
      ridx_d      = ridx_q;
      rlen_d      = rlen_q;
      rcnt_d      = rcnt_q;
      axi_arready = 1'b0;
      axi_rvalid  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            axi_arready = axi_resetn && ar_id_ok;
            if (axi_arvalid && axi_arready) begin
               rid_d     = axi_arid;
               ridx_d    = axi_araddr[AW-1:0];
               rlen_d    = LW'(axi_arlen) + LW'(1);
               rcnt_d    = LW'(1);
               rdata_d   = mem_q[axi_araddr[AW-1:0]];
               rlast_d   = (axi_arlen == '0);
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            axi_rvalid = 1'b1;
            if (axi_rready) begin
               if (rlast_q) begin
                  rlast_d   = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  ridx_d  = ridx_nxt;
                  rdata_d = mem_q[ridx_nxt];
                  rcnt_d  = rcnt_q + LW'(1);
                  rlast_d = ((rcnt_q + LW'(1)) == rlen_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Memory array: written on accepted data beats, never cleared by reset
   always_ff @(posedge axi_aclk) begin
      if (mem_we) begin
         mem_q[widx_q] <= axi_wdata;
      end
   end

   // Channel state registers; reset abandons any burst in flight
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         w_state_q <= W_IDLE;
         bid_q     <= '0;
         bresp_q   <= 2'b00;
         widx_q    <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         r_state_q <= R_IDLE;
         rid_q     <= '0;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rlast_q   <= rlast_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
      end
   end

endmodule

// File: doc/axi_slave_ram.md
AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 ASIZE, 32, address width, bits.
REQ-002 DSIZE, 64, data width, bits.
REQ-003 IDSIZE, 4, ID width, bits.
REQ-004 LSIZE, 8, burst length field width, bits.
REQ-005 ID, 0, ID this responder answers when filtering is compiled in.
REQ-006 DEPTH, 1024, memory depth in DSIZE words; power of two.
REQ-007 axi_aclk  in  1  single clock; all logic on rising edge.
REQ-008 axi_resetn  in  1  reset, asynchronous, active-low.
REQ-009 axi_awid  in  IDSIZE  write address ID.
REQ-010 axi_awaddr  in  ASIZE  write start word address.
REQ-011 axi_awlen  in  LSIZE  write beats minus one.
REQ-012 axi_awvalid  in  1  write address valid.
REQ-013 axi_awready  out  1  write address ready.
REQ-014 axi_wdata  in  DSIZE  write data.
REQ-015 axi_wlast  in  1  last write beat.
REQ-016 axi_wvalid  in  1  write data valid.
REQ-017 axi_wready  out  1  write data ready.
REQ-018 axi_bid  out  IDSIZE  response ID.
REQ-019 axi_bresp  out  2  write response, OKAY=00, SLVERR=10.
REQ-020 axi_bvalid  out  1  response valid.
REQ-021 axi_bready  in  1  response ready.
REQ-022 axi_arid  in  IDSIZE  read address ID.
REQ-023 axi_araddr  in  ASIZE  read start word address.
REQ-024 axi_arlen  in  LSIZE  read beats minus one.
REQ-025 axi_arvalid  in  1  read address valid.
REQ-026 axi_arready  out  1  read address ready.
REQ-027 axi_rid  out  IDSIZE  read data ID.
REQ-028 axi_rdata  out  DSIZE  read data.
REQ-029 axi_rresp  out  2  read response, always OKAY=00.
REQ-030 axi_rlast  out  1  last read beat.
REQ-031 axi_rvalid  out  1  read data valid.
REQ-032 axi_rready  in  1  read data ready.

Function
REQ-033 The write FSM (W_IDLE, W_DATA, W_RESP) and the read FSM (R_IDLE, R_DATA) SHALL run independently and concurrently.
REQ-034 Write channel: awready=1 only in W_IDLE; on aw handshake, latch awid, awaddr[log2(DEPTH)-1:0] and awlen+1, then go to W_DATA next cycle.
REQ-035 W_DATA: wready=1; each wvalid&&wready beat writes mem[idx], idx increments by one and wraps DEPTH-1 to 0, and the beat counter increments.
REQ-036 On the beat with wlast=1, go to W_RESP; bresp=SLVERR if the beat count differs from awlen+1, else OKAY; beats beyond awlen+1 without wlast are still written.
REQ-037 W_RESP: bvalid=1 and bid equal to the latched awid, held stable until bready; then return to W_IDLE.
REQ-038 Read channel: arready=1 only in R_IDLE; on ar handshake, latch arid, the index and arlen+1; rvalid rises on the next cycle with rdata=mem[start].
REQ-039 R_DATA: rdata, rid and rlast are held while rvalid&&!rready; on each handshake, advance idx with wrap and present the next word one cycle later.
REQ-040 rlast=1 exactly on beat arlen+1; after its handshake, rvalid=0 and return to R_IDLE.
REQ-041 When a write and a read hit the same word in the same cycle, the read SHALL return the pre-write value.

Reset
REQ-042 While axi_resetn=0: both FSMs in IDLE; awready, wready, bvalid, arready, rvalid and rlast all 0; bid, rid, bresp, rresp and rdata all 0; memory contents not cleared. Reset mid-burst abandons the burst, and no response is issued.

Configuration
REQ-043 AXI_SLAVE_RAM_ID_FILTER_EN defined: awready/arready assert only when awvalid/arvalid is 1 and awid/arid equals ID; non-matching requests are never accepted. Undefined: all IDs are accepted and ID is ignored.

Verification
REQ-044 awaddr=0x10 awlen=3, four beats 0xA0..0xA3 with wlast on beat 4 -> bvalid with bresp=00, bid=awid; mem[0x10..0x13]=A0..A3.
REQ-045 araddr=0x10 arlen=3, rready toggling 1/0 -> rdata A0,A1,A2,A3 each held while stalled; rlast only on A3.
REQ-046 awaddr=DEPTH-2 awlen=3 -> words land at DEPTH-2, DEPTH-1, 0, 1; a readback confirms the wrap.
REQ-047 awlen=3 with wlast on beat 2 -> bresp=10; bvalid held for 5 cycles with bready=0.
REQ-048 With AXI_SLAVE_RAM_ID_FILTER_EN and ID=2, arid=5 -> arready stays 0 for 20 cycles; arid=2 -> accepted. axi_resetn low during R_DATA -> rvalid=0 in the same cycle.
